// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder stage.
// Holds the frame geometry (N, LOG2N, DW), the bit-reversal helper used to
// place each incoming bin in natural order, and the reader state encoding.
// Optional build macro used by the stage: FFT_REORDER_MAG_EN.
package fft_pkg;

  localparam int N     = 4;
  localparam int LOG2N = 2;
  localparam int DW    = 18;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Streaming bus between the FFT core, the reorder stage and its consumer.
// Input side : in_valid, in_sop, in_r, in_i (bit-reversed bin order).
// Output side: out_valid, out_sop, out_eop, out_idx, out_r, out_i (natural
//              order) and, when FFT_REORDER_MAG_EN is defined, out_mag.
// modport slave  : the reorder stage (consumes in_*, drives out_*).
// modport master : the environment (drives in_*, observes out_*).
interface fft_out_reorder_if;
  import fft_pkg::*;

  logic                 in_valid;
  logic                 in_sop;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;

  logic                 out_valid;
  logic                 out_sop;
  logic                 out_eop;
  logic [LOG2N-1:0]     out_idx;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;

`ifdef FFT_REORDER_MAG_EN
  logic [2*DW:0]        out_mag;

  modport slave (
    input  in_valid, in_sop, in_r, in_i,
    output out_valid, out_sop, out_eop, out_idx, out_r, out_i, out_mag
  );

  modport master (
    output in_valid, in_sop, in_r, in_i,
    input  out_valid, out_sop, out_eop, out_idx, out_r, out_i, out_mag
  );
`else
  modport slave (
    input  in_valid, in_sop, in_r, in_i,
    output out_valid, out_sop, out_eop, out_idx, out_r, out_i
  );

  modport master (
    output in_valid, in_sop, in_r, in_i,
    input  out_valid, out_sop, out_eop, out_idx, out_r, out_i
  );
`endif

endinterface

// File: rtl/fft_reorder_bank.sv
// Ping-pong frame store: simple dual-port RAM of 2*N words, each word the
// packed {real, imag} pair. Address is {bank, idx}.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read port with
// a registered rd_data (one cycle read latency).
module fft_reorder_bank import fft_pkg::*; (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LOG2N:0]    wr_addr,
  input  logic [2*DW-1:0]   wr_data,
  input  logic              rd_en,
  input  logic [LOG2N:0]    rd_addr,
  output logic [2*DW-1:0]   rd_data
);

  logic [2*DW-1:0] mem [2*N];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder stage. Buffers each bit-reversed frame from the FFT core
// in one half of a ping-pong RAM and replays it in natural order with
// sop/eop framing and a bin index.
// Ports: clk, rst (synchronous, active-high); bus (fft_out_reorder_if.slave)
// carrying the in_* stream and the out_* stream.
// Build option FFT_REORDER_MAG_EN adds out_mag = out_r^2 + out_i^2 and one
// extra output register (last bin in at edge t -> sop out at t+3, else t+2).
module fft_out_reorder import fft_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  fft_out_reorder_if.slave   bus
);

  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N-1);

`ifdef FFT_REORDER_MAG_EN
  localparam int MW = 2*DW+1;

  // Operands widened before multiplying so the full-precision sum fits.
  function automatic logic [MW-1:0] mag_sq(input logic signed [DW-1:0] re,
                                           input logic signed [DW-1:0] im);
    logic signed [MW-1:0] re_x;
    logic signed [MW-1:0] im_x;
    re_x = MW'(re);
    im_x = MW'(im);
    return $unsigned(re_x * re_x + im_x * im_x);
  endfunction
`endif

  logic [LOG2N-1:0]     wr_cnt;
  logic                 wr_bank;
  logic                 wr_last;
  logic [LOG2N-1:0]     wr_idx;
  logic [1:0]           ready;
  logic [1:0]           ready_nxt;

  rd_state_t            state;
  logic                 rd_bank;
  logic [LOG2N-1:0]     rd_cnt;
  logic [LOG2N-1:0]     rd_idx;
  logic                 rd_last;
  logic                 issue;

  logic [2*DW-1:0]      rd_data;

  // A resync (sop) restarts the frame at address 0, so it never completes one.
  always_comb begin
    wr_last = bus.in_valid && !bus.in_sop && (wr_cnt == CNT_LAST);
    wr_idx  = bus.in_sop ? '0 : bitrev(wr_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (bus.in_valid) begin
      if (bus.in_sop) begin
        wr_cnt <= CNT_ONE;
      end else begin
        wr_cnt <= wr_cnt + CNT_ONE;
        if (wr_last) wr_bank <= ~wr_bank;
      end
    end
  end

  // Index 0 is issued straight from IDLE so the first read overlaps the state
  // change; that keeps back-to-back frames gap-free and sop at t+2.
  always_comb begin
    issue     = (state == READ) || ready[rd_bank];
    rd_idx    = (state == READ) ? rd_cnt : '0;
    rd_last   = (state == READ) && (rd_cnt == CNT_LAST);
    ready_nxt = ready;
    if (rd_last) ready_nxt[rd_bank] = 1'b0;
    if (wr_last) ready_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      ready   <= '0;
    end else begin
      ready <= ready_nxt;
      case (state)
        IDLE: begin
          if (ready[rd_bank]) begin
            state  <= READ;
            rd_cnt <= CNT_ONE;
          end
        end
        READ: begin
          if (rd_last) begin
            rd_bank <= ~rd_bank;
            rd_cnt  <= '0;
            if (!ready[~rd_bank]) state <= IDLE;
          end else begin
            rd_cnt <= rd_cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_reorder_bank u_bank (
    .clk     (clk),
    .wr_en   (bus.in_valid && !rst),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data ({bus.in_r, bus.in_i}),
    .rd_en   (issue),
    .rd_addr ({rd_bank, rd_idx}),
    .rd_data (rd_data)
  );

  // ---- stage p0: RAM read registered, control tracks it ----
  logic             vld_p0;
  logic [LOG2N-1:0] idx_p0;

  always_ff @(posedge clk) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= issue;
    idx_p0 <= rd_idx;
  end

  // ---- stage p1: framing decoded, data registered ----
  logic                 vld_p1;
  logic                 sop_p1;
  logic                 eop_p1;
  logic [LOG2N-1:0]     idx_p1;
  logic signed [DW-1:0] r_p1;
  logic signed [DW-1:0] i_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      sop_p1 <= 1'b0;
      eop_p1 <= 1'b0;
      idx_p1 <= '0;
      r_p1   <= '0;
      i_p1   <= '0;
    end else begin
      vld_p1 <= vld_p0;
      sop_p1 <= vld_p0 && (idx_p0 == '0);
      eop_p1 <= vld_p0 && (idx_p0 == CNT_LAST);
      if (vld_p0) begin
        idx_p1 <= idx_p0;
        r_p1   <= $signed(rd_data[2*DW-1:DW]);
        i_p1   <= $signed(rd_data[DW-1:0]);
      end
    end
  end

`ifdef FFT_REORDER_MAG_EN
  // ---- stage p2: magnitude squared, everything shifted together ----
  logic                 vld_p2;
  logic                 sop_p2;
  logic                 eop_p2;
  logic [LOG2N-1:0]     idx_p2;
  logic signed [DW-1:0] r_p2;
  logic signed [DW-1:0] i_p2;
  logic [MW-1:0]        mag_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      sop_p2 <= 1'b0;
      eop_p2 <= 1'b0;
      idx_p2 <= '0;
      r_p2   <= '0;
      i_p2   <= '0;
      mag_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      sop_p2 <= sop_p1;
      eop_p2 <= eop_p1;
      idx_p2 <= idx_p1;
      r_p2   <= r_p1;
      i_p2   <= i_p1;
      mag_p2 <= mag_sq(r_p1, i_p1);
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_sop   = sop_p2;
  assign bus.out_eop   = eop_p2;
  assign bus.out_idx   = idx_p2;
  assign bus.out_r     = r_p2;
  assign bus.out_i     = i_p2;
  assign bus.out_mag   = mag_p2;
`else
  assign bus.out_valid = vld_p1;
  assign bus.out_sop   = sop_p1;
  assign bus.out_eop   = eop_p1;
  assign bus.out_idx   = idx_p1;
  assign bus.out_r     = r_p1;
  assign bus.out_i     = i_p1;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder. Expected natural-order bins are
// pushed to a scoreboard queue when a frame is driven and popped by a monitor
// as the DUT emits them. Covers FFT_REORDER_MAG_EN when defined.
module tb_fft_out_reorder;
  import fft_pkg::*;

  localparam int MW = 2*DW+1;
`ifdef FFT_REORDER_MAG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int                   idx;
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
    logic                 sop;
    logic                 eop;
    longint               mag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_out_reorder_if bus();

  fft_out_reorder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   out_seen = 0;
  int   bursts = 0;
  int   sop_cyc = -1;
  int   last_in_cyc = 0;
  logic signed [DW-1:0] fr [N];
  logic signed [DW-1:0] fi [N];

  function automatic int tb_rev(input int k);
    int r = 0;
    for (int b = 0; b < LOG2N; b++)
      if (k[b]) r = r | (1 << (LOG2N-1-b));
    return r;
  endfunction

  // Natural-order bin k is the sample that arrived in input slot bitrev(k).
  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      int p = tb_rev(k);
      e.idx = k;
      e.r   = fr[p];
      e.i   = fi[p];
      e.sop = (k == 0);
      e.eop = (k == N-1);
      e.mag = longint'(fr[p]) * longint'(fr[p]) + longint'(fi[p]) * longint'(fi[p]);
      sbq.push_back(e);
    end
  endtask

  task automatic drive_bin(input logic v, input logic s,
                           input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
    bus.in_valid = v;
    bus.in_sop   = s;
    bus.in_r     = r;
    bus.in_i     = i;
    @(posedge clk);
    #1;
    if (v) last_in_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bin(1'b0, 1'b0, '0, '0);
  endtask

  task automatic send_frame(input bit gap);
    for (int p = 0; p < N; p++) begin
      drive_bin(1'b1, (p == 0), fr[p], fi[p]);
      if (gap) idle(1);
    end
  endtask

  task automatic rand_frame();
    for (int p = 0; p < N; p++) begin
      fr[p] = DW'($urandom);
      fi[p] = DW'($urandom);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (sbq.size() != 0 && c < 80) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    logic prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        out_seen++;
        if (prev_valid !== 1'b1) bursts++;
        if (bus.out_sop === 1'b1) sop_cyc = cyc;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got idx=%0d r=%h i=%h, want no output",
                   bus.out_idx, bus.out_r, bus.out_i);
        end else begin
          e = sbq.pop_front();
          if (bus.out_idx !== LOG2N'(e.idx) || bus.out_r !== e.r || bus.out_i !== e.i ||
              bus.out_sop !== e.sop || bus.out_eop !== e.eop) begin
            errors++;
            $display("FAIL out_data: got idx=%0d r=%h i=%h sop=%b eop=%b, want idx=%0d r=%h i=%h sop=%b eop=%b",
                     bus.out_idx, bus.out_r, bus.out_i, bus.out_sop, bus.out_eop,
                     e.idx, e.r, e.i, e.sop, e.eop);
          end
`ifdef FFT_REORDER_MAG_EN
          checks++;
          if (bus.out_mag !== MW'(e.mag)) begin
            errors++;
            $display("FAIL out_mag: got %0d, want %0d (idx %0d)", bus.out_mag, e.mag, e.idx);
          end
`endif
        end
      end
      prev_valid = bus.out_valid;
    end
  endtask

  task automatic test_reset();
    int base;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) drive_bin(1'b1, (k == 0), 18'sh155, 18'sh0aa);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sop !== 1'b0 || bus.out_eop !== 1'b0 ||
        bus.out_idx !== '0 || bus.out_r !== '0 || bus.out_i !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b sop=%b eop=%b idx=%0d r=%h i=%h, want all 0",
               bus.out_valid, bus.out_sop, bus.out_eop, bus.out_idx, bus.out_r, bus.out_i);
    end
    rst = 1'b0;
    base = out_seen;
    rand_frame();
    for (int p = 0; p < N-1; p++) drive_bin(1'b1, (p == 0), fr[p], fi[p]);
    idle(6);
    checks++;
    if (out_seen != base) begin
      errors++;
      $display("FAIL reset_partial_quiet: got %0d outputs, want 0", out_seen - base);
    end
    push_frame();
    drive_bin(1'b1, 1'b0, fr[N-1], fi[N-1]);
    idle(1);
    wait_drain();
    checks++;
    if (out_seen - base != N) begin
      errors++;
      $display("FAIL reset_first_frame: got %0d outputs, want %0d", out_seen - base, N);
    end
  endtask

  task automatic test_single();
    int base = out_seen;
    int bb = bursts;
    for (int p = 0; p < N; p++) begin
      fr[p] = DW'(tb_rev(p) * 'h100);
      fi[p] = fr[p];
    end
    push_frame();
    send_frame(1'b0);
    idle(1);
    wait_drain();
    checks++;
    if (sop_cyc - last_in_cyc != LAT) begin
      errors++;
      $display("FAIL single_latency: got %0d, want %0d", sop_cyc - last_in_cyc, LAT);
    end
    checks++;
    if (out_seen - base != N || bursts - bb != 1 || sbq.size() != 0) begin
      errors++;
      $display("FAIL single_count: got %0d outs in %0d bursts, %0d pending, want %0d in 1, 0",
               out_seen - base, bursts - bb, sbq.size(), N);
    end
  endtask

  task automatic test_gapped();
    int base = out_seen;
    int bb = bursts;
    for (int p = 0; p < N; p++) begin
      fr[p] = DW'(tb_rev(p) * 'h100);
      fi[p] = fr[p];
    end
    push_frame();
    send_frame(1'b1);
    wait_drain();
    checks++;
    if (out_seen - base != N || bursts - bb != 1 || sbq.size() != 0) begin
      errors++;
      $display("FAIL gapped_burst: got %0d outs in %0d bursts, %0d pending, want %0d in 1, 0",
               out_seen - base, bursts - bb, sbq.size(), N);
    end
    checks++;
    if (sop_cyc - last_in_cyc != LAT) begin
      errors++;
      $display("FAIL gapped_latency: got %0d, want %0d", sop_cyc - last_in_cyc, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int base = out_seen;
    int bb = bursts;
    for (int f = 0; f < 8; f++) begin
      rand_frame();
      push_frame();
      send_frame(1'b0);
    end
    idle(1);
    wait_drain();
    checks++;
    if (out_seen - base != 8*N || bursts - bb != 1 || sbq.size() != 0) begin
      errors++;
      $display("FAIL b2b_stream: got %0d outs in %0d bursts, %0d pending, want %0d in 1, 0",
               out_seen - base, bursts - bb, sbq.size(), 8*N);
    end
  endtask

  task automatic test_resync();
    int base = out_seen;
    drive_bin(1'b1, 1'b1, 18'sh1111, -18'sh1111);
    drive_bin(1'b1, 1'b0, 18'sh2222, -18'sh2222);
    rand_frame();
    push_frame();
    send_frame(1'b0);
    idle(1);
    wait_drain();
    checks++;
    if (out_seen - base != N || sbq.size() != 0) begin
      errors++;
      $display("FAIL resync_frame: got %0d outs, %0d pending, want %0d, 0",
               out_seen - base, sbq.size(), N);
    end
    checks++;
    if (sop_cyc - last_in_cyc != LAT) begin
      errors++;
      $display("FAIL resync_latency: got %0d, want %0d", sop_cyc - last_in_cyc, LAT);
    end
  endtask

  task automatic test_reset_mid_read();
    int base = out_seen;
    bit hit = 0;
    rand_frame();
    push_frame();
    repeat (N-2) void'(sbq.pop_back());
    send_frame(1'b0);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_idx == LOG2N'(1)) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrst_wait: got no idx 1 output in 20 cycles, want one");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: got out_valid=%b, want 0", bus.out_valid);
    end
    rst = 1'b0;
    idle(6);
    checks++;
    if (out_seen - base != 2 || sbq.size() != 0) begin
      errors++;
      $display("FAIL midrst_tail: got %0d outs, %0d pending, want 2, 0", out_seen - base, sbq.size());
    end
    base = out_seen;
    rand_frame();
    push_frame();
    send_frame(1'b0);
    idle(1);
    wait_drain();
    checks++;
    if (out_seen - base != N || sbq.size() != 0) begin
      errors++;
      $display("FAIL midrst_clean: got %0d outs, %0d pending, want %0d, 0", out_seen - base, sbq.size(), N);
    end
  endtask

`ifdef FFT_REORDER_MAG_EN
  task automatic test_mag();
    bit hit = 0;
    rand_frame();
    fr[0] = 18'sd3;
    fi[0] = 18'sd4;
    fr[1] = -18'sd131072;
    fi[1] = -18'sd131072;
    push_frame();
    send_frame(1'b0);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    for (int c = 0; c < 12 && !hit; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_sop === 1'b1) hit = 1;
    end
    checks++;
    if (!hit || bus.out_mag !== MW'(25)) begin
      errors++;
      $display("FAIL mag_345: got seen=%0d mag=%0d, want seen=1 mag=25", hit, bus.out_mag);
    end
    checks++;
    if (sop_cyc - last_in_cyc != LAT) begin
      errors++;
      $display("FAIL mag_latency: got %0d, want %0d", sop_cyc - last_in_cyc, LAT);
    end
    wait_drain();
  endtask
`endif

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_r     = '0;
    bus.in_i     = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_gapped();
    test_back_to_back();
    test_resync();
    test_reset_mid_read();
`ifdef FFT_REORDER_MAG_EN
    test_mag();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
